data_memory_ls: RTL and testbench

- Parametrised successor to the single-port word data memory.
- Byte-addressed load/store memory for the single-cycle/pipelined CPU.
- Supports byte/half/word access with sign/zero extension, misalignment detection, and a valid/ready request channel.
- Configurable read latency and a power-up zero-fill sequencer.

---
 rtl/data_memory_ls.sv | 177 +++++++++++++++++
 tb/tb_data_memory_ls.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_ls.sv
// data_memory_ls: byte-addressed load/store data memory with a valid/ready
// request channel, byte/half/word access, sign/zero extension, misalignment
// detection, configurable read latency and a power-up zero-fill sequencer.
//
// Parameters:
//   WORDS        number of 32-bit words (power of two, >= 4)
//   READ_LATENCY cycles from request accept to response (1..4)
//   ZERO_INIT    1 = clear every word after reset before accepting requests
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   reqValid/reqReady   request handshake (accept when both high at an edge)
//   reqWrite            1 = store, 0 = load
//   reqSize             00 byte, 01 half, 10 word, 11 reserved
//   reqSigned           loads only: sign-extend when 1
//   reqAddr             byte address
//   reqData             store data, right-justified
//   respValid           one-cycle pulse per accepted request, in order
//   respData            load result (0 for stores, errors and idle cycles)
//   respError           misaligned or reserved-size request
//
// Optional feature macro: DMEM_WRITE_THROUGH_EN
//   When defined, a successful store response carries the post-write word.
module data_memory_ls #(
  parameter int unsigned WORDS        = 1024,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned ZERO_INIT    = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         reqValid,
  output logic                         reqReady,
  input  logic                         reqWrite,
  input  logic [1:0]                   reqSize,
  input  logic                         reqSigned,
  input  logic [$clog2(WORDS)+1:0]     reqAddr,
  input  logic [31:0]                  reqData,
  output logic                         respValid,
  output logic [31:0]                  respData,
  output logic                         respError
);

  localparam int unsigned IDX_W  = $clog2(WORDS);
  localparam int unsigned ADDR_W = IDX_W + 2;

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] initIdx;
  logic [31:0]      mem [WORDS];

  logic             accept;
  logic             storeEn;
  logic [IDX_W-1:0] wordIdx;
  logic [1:0]       lane;
  logic             sizeErr;
  logic [3:0]       byteEn;
  logic [31:0]      bitMask;
  logic [31:0]      wrData;
  logic [31:0]      curWord;
  logic [31:0]      mergedWord;
  logic [31:0]      shifted;
  logic [31:0]      loadData;
  logic [31:0]      respNext;

  logic [READ_LATENCY-1:0] validPipe;
  logic [READ_LATENCY-1:0] errorPipe;
  logic [31:0]             dataPipe [READ_LATENCY];

  // Init/run sequencer; reqReady is registered and only high in RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= (ZERO_INIT != 0) ? INIT : RUN;
      initIdx  <= '0;
      reqReady <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          reqReady <= 1'b0;
          initIdx  <= initIdx + IDX_W'(1);
          if (initIdx == IDX_W'(WORDS - 1)) begin
            state    <= RUN;
            reqReady <= 1'b1;
          end
        end
        RUN:     reqReady <= 1'b1;
        default: state    <= RUN;
      endcase
    end
  end

  assign accept  = reqValid && reqReady;
  assign wordIdx = reqAddr[ADDR_W-1:2];
  assign lane    = reqAddr[1:0];
  assign storeEn = accept && reqWrite && !sizeErr && !reset;

  // Request decode: error check, lane enables, store merge and load extract.
  always_comb begin
    sizeErr    = 1'b0;
    byteEn     = 4'b0000;
    wrData     = reqData;
    bitMask    = '0;
    curWord    = mem[wordIdx];
    shifted    = curWord >> {lane, 3'b000};
    loadData   = curWord;
    case (reqSize)
      2'b00: begin
        byteEn   = 4'b0001 << lane;
        wrData   = {4{reqData[7:0]}};
        loadData = {{24{reqSigned & shifted[7]}}, shifted[7:0]};
      end
      2'b01: begin
        sizeErr  = lane[0];
        byteEn   = lane[1] ? 4'b1100 : 4'b0011;
        wrData   = {2{reqData[15:0]}};
        loadData = {{16{reqSigned & shifted[15]}}, shifted[15:0]};
      end
      2'b10: begin
        sizeErr  = (lane != 2'b00);
        byteEn   = 4'b1111;
      end
      default: sizeErr = 1'b1;
    endcase
    for (int i = 0; i < 4; i++) begin
      bitMask[8*i +: 8] = {8{byteEn[i]}};
    end
    mergedWord = (curWord & ~bitMask) | (wrData & bitMask);
    if (sizeErr) begin
      respNext = '0;
    end else if (reqWrite) begin
`ifdef DMEM_WRITE_THROUGH_EN
      respNext = mergedWord;
`else
      respNext = '0;
`endif
    end else begin
      respNext = loadData;
    end
  end

  // Array write port: zero-fill during INIT, merged store otherwise.
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      mem[initIdx] <= '0;
    end else if (storeEn) begin
      mem[wordIdx] <= mergedWord;
    end
  end

  // Response pipeline; stage 0 captures the array read at the accept edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      validPipe <= '0;
      errorPipe <= '0;
      for (int i = 0; i < int'(READ_LATENCY); i++) begin
        dataPipe[i] <= '0;
      end
    end else begin
      validPipe[0] <= accept;
      errorPipe[0] <= accept && sizeErr;
      dataPipe[0]  <= accept ? respNext : '0;
      for (int i = 1; i < int'(READ_LATENCY); i++) begin
        validPipe[i] <= validPipe[i-1];
        errorPipe[i] <= errorPipe[i-1];
        dataPipe[i]  <= dataPipe[i-1];
      end
    end
  end

  assign respValid = validPipe[READ_LATENCY-1];
  assign respError = errorPipe[READ_LATENCY-1];
  assign respData  = dataPipe[READ_LATENCY-1];

endmodule

// File: tb/tb_data_memory_ls.sv
// Directed self-checking bench for data_memory_ls (WORDS=16, READ_LATENCY=3).
module tb_data_memory_ls;

  localparam int unsigned LAT = 3;

`ifdef DMEM_WRITE_THROUGH_EN
  localparam logic WT = 1'b1;
`else
  localparam logic WT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        reqValid;
  logic        reqReady;
  logic        reqWrite;
  logic [1:0]  reqSize;
  logic        reqSigned;
  logic [5:0]  reqAddr;
  logic [31:0] reqData;
  logic        respValid;
  logic [31:0] respData;
  logic        respError;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  data_memory_ls #(
    .WORDS(16),
    .READ_LATENCY(LAT),
    .ZERO_INIT(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .reqValid(reqValid),
    .reqReady(reqReady),
    .reqWrite(reqWrite),
    .reqSize(reqSize),
    .reqSigned(reqSigned),
    .reqAddr(reqAddr),
    .reqData(reqData),
    .respValid(respValid),
    .respData(respData),
    .respError(respError)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one request from a negedge, wait for its response, check latency.
  task automatic doReq(input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [5:0] addr, input logic [31:0] data,
                       output logic [31:0] rd, output logic er);
    int k;
    reqValid  = 1'b1;
    reqWrite  = wr;
    reqSize   = sz;
    reqSigned = sg;
    reqAddr   = addr;
    reqData   = data;
    @(posedge clk);
    @(negedge clk);
    reqValid = 1'b0;
    k = 1;
    while (!respValid && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("latency", 32'(k), 32'(LAT));
    rd = respData;
    er = respError;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          cnt;
    logic        sawResp;
    logic [1:0]  bSz  [4] = '{2'b10, 2'b00, 2'b10, 2'b01};
    logic        bSg  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [5:0]  bAdr [4] = '{6'h10, 6'h12, 6'h20, 6'h22};
    logic [31:0] bExp [4] = '{32'h11AB3344, 32'hFFFFFFAB, 32'h80010000, 32'h00008001};
    logic [31:0] expD;

    reset = 1'b1; reqValid = 1'b0; reqWrite = 1'b0; reqSize = 2'b00;
    reqSigned = 1'b0; reqAddr = '0; reqData = '0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_reqReady",  32'(reqReady),  32'd0);
    chk("rst_respValid", 32'(respValid), 32'd0);
    chk("rst_respData",  respData,       32'd0);
    chk("rst_respError", 32'(respError), 32'd0);

    // Zero-init takes WORDS cycles.
    reset = 1'b0;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!reqReady && cnt < 40);
    chk("init_cycles", 32'(cnt), 32'd16);
    doReq(1'b0, 2'b10, 1'b0, 6'h3C, 32'h0, rd, er);
    chk("zero_load", rd, 32'h0);
    chk("zero_load_err", 32'(er), 32'd0);

    // Byte store/load.
    doReq(1'b1, 2'b10, 1'b0, 6'h10, 32'h11223344, rd, er);
    chk("st_word_data", rd, WT ? 32'h11223344 : 32'h0);
    chk("st_word_err", 32'(er), 32'd0);
    doReq(1'b1, 2'b00, 1'b0, 6'h12, 32'h000000AB, rd, er);
    chk("st_byte_data", rd, WT ? 32'h11AB3344 : 32'h0);
    doReq(1'b0, 2'b10, 1'b0, 6'h10, 32'h0, rd, er);
    chk("ld_word_merged", rd, 32'h11AB3344);
    doReq(1'b0, 2'b00, 1'b1, 6'h12, 32'h0, rd, er);
    chk("ld_byte_signed", rd, 32'hFFFFFFAB);
    doReq(1'b0, 2'b00, 1'b0, 6'h12, 32'h0, rd, er);
    chk("ld_byte_unsigned", rd, 32'h000000AB);

    // Half access and misalignment.
    doReq(1'b1, 2'b01, 1'b0, 6'h22, 32'h00008001, rd, er);
    chk("st_half_err", 32'(er), 32'd0);
    doReq(1'b0, 2'b01, 1'b1, 6'h22, 32'h0, rd, er);
    chk("ld_half_signed", rd, 32'hFFFF8001);
    doReq(1'b1, 2'b01, 1'b0, 6'h23, 32'h00005555, rd, er);
    chk("st_half_mis_err", 32'(er), 32'd1);
    chk("st_half_mis_data", rd, 32'h0);
    doReq(1'b0, 2'b10, 1'b0, 6'h20, 32'h0, rd, er);
    chk("ld_word_unchanged", rd, 32'h80010000);
    doReq(1'b0, 2'b10, 1'b0, 6'h21, 32'h0, rd, er);
    chk("ld_word_mis_err", 32'(er), 32'd1);
    chk("ld_word_mis_data", rd, 32'h0);
    doReq(1'b0, 2'b11, 1'b0, 6'h20, 32'h0, rd, er);
    chk("ld_reserved_err", 32'(er), 32'd1);
    chk("ld_reserved_data", rd, 32'h0);
    doReq(1'b0, 2'b01, 1'b0, 6'h20, 32'h0, rd, er);
    chk("ld_half_low_zero", rd, 32'h0);

    // Four back-to-back loads: responses on negedges 3..6 after first accept.
    reqValid = 1'b1; reqWrite = 1'b0;
    reqSize = bSz[0]; reqSigned = bSg[0]; reqAddr = bAdr[0];
    @(posedge clk);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      expD = (k >= 3 && k <= 6) ? bExp[k-3] : 32'h0;
      chk($sformatf("b2b_valid_%0d", k), 32'(respValid), (k >= 3 && k <= 6) ? 32'd1 : 32'd0);
      chk($sformatf("b2b_data_%0d", k), respData, expD);
      if (k <= 3) begin
        reqSize = bSz[k]; reqSigned = bSg[k]; reqAddr = bAdr[k];
      end else begin
        reqValid = 1'b0;
      end
      if (k <= 3) @(posedge clk);
      else if (k < 7) @(posedge clk);
    end

    // Reset with two loads in flight: no responses, INIT reruns.
    reqValid = 1'b1; reqSize = 2'b10; reqSigned = 1'b0; reqAddr = 6'h10;
    @(posedge clk);
    @(negedge clk);
    reqAddr = 6'h20;
    @(posedge clk);
    @(negedge clk);
    reqValid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    sawResp = respValid;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
      if (respValid) sawResp = 1'b1;
    end while (!reqReady && cnt < 40);
    chk("flush_no_resp", 32'(sawResp), 32'd0);
    chk("reinit_cycles", 32'(cnt), 32'd16);

    // Reset during INIT restarts the fill from index 0.
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("init_busy", 32'(reqReady), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!reqReady && cnt < 40);
    chk("restart_init_cycles", 32'(cnt), 32'd16);
    doReq(1'b0, 2'b10, 1'b0, 6'h10, 32'h0, rd, er);
    chk("cleared_after_init", rd, 32'h0);

    // Store response contents (write-through when enabled).
    doReq(1'b1, 2'b10, 1'b0, 6'h00, 32'hCAFEBABE, rd, er);
    doReq(1'b1, 2'b00, 1'b0, 6'h01, 32'h00000000, rd, er);
    chk("wt_store_data", rd, WT ? 32'hCAFE00BE : 32'h0);
    doReq(1'b0, 2'b10, 1'b0, 6'h00, 32'h0, rd, er);
    chk("wt_load_back", rd, 32'hCAFE00BE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
